// File: rtl/glyph_fetch_arb_pkg.sv
// Shared font-fetch definitions: address geometry, port tag type and the
// {code,row} byte-address packing used by glyph_fetch_arb.
package glyph_fetch_arb_pkg;

    localparam int unsigned FONT_AW    = 11;
    localparam int unsigned GLYPH_ROWS = 8;
    localparam int unsigned ROW_W      = $clog2(GLYPH_ROWS);

    typedef enum logic {
        PORT_P0 = 1'b0,
        PORT_P1 = 1'b1
    } port_tag_t;

    function automatic logic [FONT_AW-1:0] glyph_addr(input logic [7:0]       code,
                                                      input logic [ROW_W-1:0] row);
        return {code, row};
    endfunction

endpackage

// File: rtl/glyph_lat_pipe.sv
// ROM_LAT-deep valid/tag shift register matching the font-ROM read latency,
// so each returning byte can be steered to the port that issued it.
module glyph_lat_pipe
    import glyph_fetch_arb_pkg::*;
#(
    parameter int unsigned ROM_LAT = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      issue_valid,
    input  port_tag_t issue_tag,
    output logic      ret_valid,
    output port_tag_t ret_tag
);

    logic [ROM_LAT-1:0] vld_q;
    port_tag_t          tag_q [ROM_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue_valid;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Tags are only meaningful alongside a set valid bit, so they skip reset.
    always_ff @(posedge clk) begin
        tag_q[0] <= issue_tag;
        for (int unsigned i = 1; i < ROM_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        ret_valid = vld_q[ROM_LAT-1];
        ret_tag   = tag_q[ROM_LAT-1];
    end

endmodule

// File: rtl/glyph_fetch_arb.sv
// Two-port font-ROM fetch arbiter (video p0, CPU readback p1), one issue per cycle.
// Define GLYPH_ARB_ROUND_ROBIN_EN for alternating tie grants; default is p0 priority.
module glyph_fetch_arb #(
    parameter int unsigned ROM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [7:0]  p0_code,
    input  logic [2:0]  p0_row,
    output logic        p0_rsp_valid,
    output logic [7:0]  p0_rsp_data,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [7:0]  p1_code,
    input  logic [2:0]  p1_row,
    output logic        p1_rsp_valid,
    output logic [7:0]  p1_rsp_data,
    output logic        rom_ce,
    output logic        rom_oce,
    output logic        rom_reset,
    output logic [10:0] rom_ad,
    input  logic [7:0]  rom_dout
);

    import glyph_fetch_arb_pkg::*;

    logic      grant0;
    logic      grant1;
    logic      prio_p1;
    logic      ret_valid;
    port_tag_t ret_tag;
    port_tag_t issue_tag;
    logic      hit0;
    logic      hit1;
    logic [7:0] hold0_q;
    logic [7:0] hold1_q;

`ifdef GLYPH_ARB_ROUND_ROBIN_EN
    // Last-granted port loses the next tie; reset leaves p0 favoured.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_p1 <= 1'b0;
        end else if (grant0 || grant1) begin
            prio_p1 <= grant0;
        end
    end
`else
    always_comb prio_p1 = 1'b0;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (p0_req_valid && p1_req_valid) begin
                grant0 = !prio_p1;
                grant1 = prio_p1;
            end else begin
                grant0 = p0_req_valid;
                grant1 = p1_req_valid;
            end
        end
    end

    always_comb begin
        p0_req_ready = grant0;
        p1_req_ready = grant1;
        rom_ce       = grant0 || grant1;
        rom_oce      = !reset;
        rom_reset    = reset;
        issue_tag    = grant1 ? PORT_P1 : PORT_P0;
        rom_ad       = '0;
        if (grant1) begin
            rom_ad = glyph_addr(p1_code, p1_row);
        end else if (grant0) begin
            rom_ad = glyph_addr(p0_code, p0_row);
        end
    end

    glyph_lat_pipe #(
        .ROM_LAT (ROM_LAT)
    ) u_lat_pipe (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (rom_ce),
        .issue_tag   (issue_tag),
        .ret_valid   (ret_valid),
        .ret_tag     (ret_tag)
    );

    always_comb begin
        hit0 = !reset && ret_valid && (ret_tag == PORT_P0);
        hit1 = !reset && ret_valid && (ret_tag == PORT_P1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            if (hit0) hold0_q <= rom_dout;
            if (hit1) hold1_q <= rom_dout;
        end
    end

    // The byte passes straight through in its return cycle; the hold register
    // only covers the idle cycles afterwards, and reset forces zero at once.
    always_comb begin
        p0_rsp_valid = hit0;
        p1_rsp_valid = hit1;
        p0_rsp_data  = '0;
        p1_rsp_data  = '0;
        if (!reset) begin
            p0_rsp_data = hit0 ? rom_dout : hold0_q;
            p1_rsp_data = hit1 ? rom_dout : hold1_q;
        end
    end

endmodule

// File: tb/tb_glyph_fetch_arb.sv
// Directed bench for glyph_fetch_arb with a two-cycle registered font-ROM model.
module tb_glyph_fetch_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_rsp_valid;
    logic [7:0]  p0_code, p0_rsp_data;
    logic [2:0]  p0_row;
    logic        p1_req_valid, p1_req_ready, p1_rsp_valid;
    logic [7:0]  p1_code, p1_rsp_data;
    logic [2:0]  p1_row;
    logic        rom_ce, rom_oce, rom_reset;
    logic [10:0] rom_ad;
    logic [7:0]  rom_dout;
    logic [7:0]  rom_s1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  glyph_a [8] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
    logic [10:0] iss_ad   [8];
    logic        iss_p1   [8];
    logic [7:0]  last0, last1;
    logic        exp_p1;
    logic [7:0]  exp_d;

    always #5 clk = ~clk;

    glyph_fetch_arb #(
        .ROM_LAT (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_code      (p0_code),
        .p0_row       (p0_row),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_data  (p0_rsp_data),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_code      (p1_code),
        .p1_row       (p1_row),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_data  (p1_rsp_data),
        .rom_ce       (rom_ce),
        .rom_oce      (rom_oce),
        .rom_reset    (rom_reset),
        .rom_ad       (rom_ad),
        .rom_dout     (rom_dout)
    );

    function automatic logic [7:0] font(input logic [10:0] a);
        if (a[10:3] == 8'h41) return glyph_a[a[2:0]];
        return a[7:0] ^ 8'h5A;
    endfunction

    // Font ROM: address registered on ce, data registered on oce.
    always_ff @(posedge clk) begin
        if (rom_ce)  rom_s1   <= font(rom_ad);
        if (rom_oce) rom_dout <= rom_s1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        p0_req_valid = 1'b0; p0_code = '0; p0_row = '0;
        p1_req_valid = 1'b0; p1_code = '0; p1_row = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        p0_req_valid = 1'b1; p0_code = 8'h41;
        p1_req_valid = 1'b1; p1_code = 8'h42;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_p0_ready", 32'(p0_req_ready), 0);
        chk("rst_p1_ready", 32'(p1_req_ready), 0);
        chk("rst_rom_ce", 32'(rom_ce), 0);
        chk("rst_rom_ad", 32'(rom_ad), 0);
        chk("rst_p0_rsp_valid", 32'(p0_rsp_valid), 0);
        chk("rst_p1_rsp_valid", 32'(p1_rsp_valid), 0);
        chk("rst_p0_rsp_data", 32'(p0_rsp_data), 0);
        chk("rst_p1_rsp_data", 32'(p1_rsp_data), 0);
        chk("rst_rom_reset", 32'(rom_reset), 1);

        // Idle after reset: no ROM activity.
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        chk("run_rom_oce", 32'(rom_oce), 1);
        chk("run_rom_reset", 32'(rom_reset), 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            chk("idle_rom_ce", 32'(rom_ce), 0);
            chk("idle_p0_rsp_valid", 32'(p0_rsp_valid), 0);
        end

        // Single p0 read of 'A' row 0.
        @(negedge clk);
        p0_req_valid = 1'b1; p0_code = 8'h41; p0_row = 3'd0;
        #1;
        chk("s31_p0_ready", 32'(p0_req_ready), 1);
        chk("s31_p1_ready", 32'(p1_req_ready), 0);
        chk("s31_rom_ce", 32'(rom_ce), 1);
        chk("s31_rom_ad", 32'(rom_ad), 32'h208);
        @(negedge clk);
        idle();
        #1;
        chk("s31_early_valid", 32'(p0_rsp_valid), 0);
        chk("s31_ce_off", 32'(rom_ce), 0);
        @(negedge clk); #1;
        chk("s31_rsp_valid", 32'(p0_rsp_valid), 1);
        chk("s31_rsp_data", 32'(p0_rsp_data), 32'h18);
        chk("s31_p1_quiet", 32'(p1_rsp_valid), 0);
        @(negedge clk); #1;
        chk("s31_valid_drop", 32'(p0_rsp_valid), 0);
        chk("s31_data_hold", 32'(p0_rsp_data), 32'h18);
        last0 = 8'h18;
        last1 = 8'h00;

        // Back-to-back p1 reads of all rows of 'A'.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            idle();
            if (k < 8) begin
                p1_req_valid = 1'b1; p1_code = 8'h41; p1_row = 3'(k);
            end
            #1;
            if (k < 8) begin
                chk("s33_p1_ready", 32'(p1_req_ready), 1);
                chk("s33_rom_ad", 32'(rom_ad), 32'({8'h41, 3'(k)}));
            end
            if (k >= 2) begin
                chk("s33_rsp_valid", 32'(p1_rsp_valid), 1);
                chk("s33_rsp_data", 32'(p1_rsp_data), 32'(glyph_a[k-2]));
                chk("s33_p0_quiet", 32'(p0_rsp_valid), 0);
                last1 = glyph_a[k-2];
            end
        end

        // Both ports held valid for four cycles.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle();
            if (k < 4) begin
                p0_req_valid = 1'b1; p0_code = 8'h10; p0_row = 3'(k);
                p1_req_valid = 1'b1; p1_code = 8'h20; p1_row = 3'(k);
`ifdef GLYPH_ARB_ROUND_ROBIN_EN
                iss_p1[k] = (k % 2) == 1;
`else
                iss_p1[k] = 1'b0;
`endif
                iss_ad[k] = iss_p1[k] ? {8'h20, 3'(k)} : {8'h10, 3'(k)};
            end
            #1;
            if (k < 4) begin
                chk("s32_p0_ready", 32'(p0_req_ready), 32'(!iss_p1[k]));
                chk("s32_p1_ready", 32'(p1_req_ready), 32'(iss_p1[k]));
                chk("s32_rom_ad", 32'(rom_ad), 32'(iss_ad[k]));
            end
            if (k >= 2) begin
                exp_p1 = iss_p1[k-2];
                exp_d  = font(iss_ad[k-2]);
                chk("s32_p0_rsp_valid", 32'(p0_rsp_valid), 32'(!exp_p1));
                chk("s32_p1_rsp_valid", 32'(p1_rsp_valid), 32'(exp_p1));
                if (exp_p1) begin
                    chk("s32_p1_rsp_data", 32'(p1_rsp_data), 32'(exp_d));
                    last1 = exp_d;
                end else begin
                    chk("s32_p0_rsp_data", 32'(p0_rsp_data), 32'(exp_d));
                    last0 = exp_d;
                end
            end
        end

        // Interleaved single-port requests, alternating every cycle.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idle();
            if (k < 6) begin
                iss_p1[k] = (k % 2) == 1;
                if (iss_p1[k]) begin
                    p1_req_valid = 1'b1; p1_code = 8'h60 + 8'(k); p1_row = 3'(k);
                    iss_ad[k] = {8'h60 + 8'(k), 3'(k)};
                end else begin
                    p0_req_valid = 1'b1; p0_code = 8'h30 + 8'(k); p0_row = 3'(k);
                    iss_ad[k] = {8'h30 + 8'(k), 3'(k)};
                end
            end
            #1;
            if (k < 6) begin
                chk("s35_rom_ce", 32'(rom_ce), 1);
                chk("s35_rom_ad", 32'(rom_ad), 32'(iss_ad[k]));
            end
            if (k >= 2) begin
                exp_p1 = iss_p1[k-2];
                exp_d  = font(iss_ad[k-2]);
                chk("s35_p0_rsp_valid", 32'(p0_rsp_valid), 32'(!exp_p1));
                chk("s35_p1_rsp_valid", 32'(p1_rsp_valid), 32'(exp_p1));
                if (exp_p1) begin
                    last1 = exp_d;
                    chk("s35_p1_rsp_data", 32'(p1_rsp_data), 32'(last1));
                    chk("s35_p0_hold", 32'(p0_rsp_data), 32'(last0));
                end else begin
                    last0 = exp_d;
                    chk("s35_p0_rsp_data", 32'(p0_rsp_data), 32'(last0));
                    chk("s35_p1_hold", 32'(p1_rsp_data), 32'(last1));
                end
            end
        end

        // Reset one cycle after a grant: the in-flight read must vanish.
        @(negedge clk);
        idle();
        p0_req_valid = 1'b1; p0_code = 8'h41; p0_row = 3'd4;
        #1;
        chk("s34_grant", 32'(rom_ce), 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            reset = 1'b1;
            p0_req_valid = 1'b1;
            p1_req_valid = 1'b1;
            #1;
            chk("s34_rom_ce", 32'(rom_ce), 0);
            chk("s34_rom_ad", 32'(rom_ad), 0);
            chk("s34_p0_ready", 32'(p0_req_ready), 0);
            chk("s34_p1_ready", 32'(p1_req_ready), 0);
            chk("s34_p0_rsp_valid", 32'(p0_rsp_valid), 0);
            chk("s34_p1_rsp_valid", 32'(p1_rsp_valid), 0);
            chk("s34_p0_rsp_data", 32'(p0_rsp_data), 0);
            chk("s34_p1_rsp_data", 32'(p1_rsp_data), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            chk("s34_post_p0_valid", 32'(p0_rsp_valid), 0);
            chk("s34_post_p1_valid", 32'(p1_rsp_valid), 0);
            chk("s34_post_rom_ce", 32'(rom_ce), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
